instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
Decoupling FIFO between the ICache fetch response and the decode stage. It accepts up to FETCH_WIDTH instructions per cycle, each with vaddr, instr, npc and fetch exception. It presents up to DECODE_WIDTH in-order instructions per cycle to decode. Flush on redirect empties it in one cycle. Its in_ready drives the ICache response ready.

Parameters:
FETCH_WIDTH, 2, instruction lanes accepted per cycle from the ICache.
DECODE_WIDTH, 2, instruction lanes presented per cycle to decode.
QUEUE_DEPTH, 16, entries; power of 2, at least 2*FETCH_WIDTH.
VALEN, 32, virtual address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  redirect: discard all contents
in_valid  in  FETCH_WIDTH  per-lane valid from ICache
in_vaddr  in  FETCH_WIDTH*VALEN  per-lane PC
in_instr  in  FETCH_WIDTH*32  per-lane instruction word
in_npc  in  FETCH_WIDTH*VALEN  per-lane predicted next PC
in_excp_valid  in  1  fetch exception, attached to lane 0
in_excp_ecode  in  6  exception code
in_ready  out  1  queue can accept a full fetch group
out_valid  out  DECODE_WIDTH  per-lane valid to decode
out_vaddr  out  DECODE_WIDTH*VALEN  per-lane PC
out_instr  out  DECODE_WIDTH*32  per-lane instruction
out_npc  out  DECODE_WIDTH*VALEN  per-lane next PC
out_excp_valid  out  DECODE_WIDTH  per-lane exception flag
out_excp_ecode  out  DECODE_WIDTH*6  per-lane exception code
out_ready  in  1  decode consumes all asserted out_valid lanes this cycle

Behaviour:
- Interface: one clock, clk. Reset is rst: synchronous, active-high.
- Storage: circular buffer with head and tail pointers of width log2(QUEUE_DEPTH), wrapping modulo QUEUE_DEPTH.
- Count register: width log2(QUEUE_DEPTH)+1.
- Reset: head, tail and count go to 0. out_valid=0. in_ready=1 from the cycle after rst deasserts.
- in_ready = (QUEUE_DEPTH - count) >= FETCH_WIDTH. Computed from the registered count only; it does not depend on a same-cycle dequeue.
- Enqueue fires when in_ready & |in_valid & ~flush_i.
- Valid lanes are compacted in lane order and written at tail, tail+1, ... Tail advances by popcount(in_valid).
- Non-contiguous masks are legal: 2'b10 writes lane 1 at tail.
- Exception fields are stored with the first valid lane. Other lanes of that group store excp_valid=0.
- out_valid[i] = (count > i) & ~flush_i. Lane i shows entry head+i.
- Exception isolation: if the head entry has excp_valid, only lane 0 is valid. If entry head+i (i>0) has excp_valid, lanes >= i are suppressed this cycle.
- Dequeue fires when out_ready & |out_valid. Head advances by popcount(out_valid).
- Simultaneous enqueue and dequeue: next count = count + enq_num - deq_num.
- Outputs are combinational from the storage array; enqueue-to-out_valid latency is 1 cycle.
- No bypass from input to output.
- flush_i: head, tail and count go to 0 next cycle. Same-cycle enqueue and dequeue are ignored. out_valid is forced to 0 during the flush cycle.
- flush_i together with rst: the reset result applies.
- Full boundary: count=15 with FETCH_WIDTH=2 gives in_ready=0. A single-lane group is also stalled, for simplicity.
- Empty: out_valid=0; out_ready is don't-care.
- Wrap: a group written at tail=15 places its second lane at index 0.
- Assertions (simulation only):
  - no enqueue when in_ready=0;
  - count never exceeds QUEUE_DEPTH.

Optional Feature:
IFQ_PERF_CNT_EN.
- Defined: adds two 32-bit output ports, perf_full_cycles and perf_empty_cycles.
  - perf_full_cycles increments each cycle that |in_valid & ~in_ready.
  - perf_empty_cycles increments each cycle that count==0.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear on rst, not on flush_i.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset, then a single enqueue of in_valid=2'b11 (PCs 0x1c000000/0x1c000004) with out_ready=0 -> next cycle out_valid=2'b11 with those PCs, count=2, in_ready=1.
- Eight enqueues of 2'b11 with out_ready=0 -> count=16, in_ready=0. A ninth group is not written. Draining 2 entries restores in_ready=1.
- Enqueue in_valid=2'b10 then 2'b11 -> entries hold lane1, lane0, lane1 in order. out_vaddr lane0 equals the first group's lane1 PC.
- Enqueue a group with in_excp_valid=1, ecode=0x08, after a normal entry -> first cycle out_valid=2'b01 (normal entry). Next cycle out_valid=2'b01 with out_excp_valid[0]=1, ecode 0x08. The following entry is shown only after that.
- Queue at count=10 with flush_i=1, simultaneous enqueue and out_ready -> out_valid=0 in the flush cycle. Next cycle count=0, in_ready=1, out_valid=0.
- Wrap test: cycle 30 groups with concurrent 2-wide dequeue -> PCs emerge strictly in order across the index 15->0 wrap. Count stays at 2.

Source files
------------

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_queue
// Brief    : Decoupling FIFO between the ICache fetch response and decode.
//            Accepts up to FETCH_WIDTH instructions per cycle, compacted into
//            a circular buffer, and presents up to DECODE_WIDTH in-order
//            entries per cycle. A redirect flush empties it in one cycle.
//            Optional feature macro: IFQ_PERF_CNT_EN (full/empty cycle
//            performance counters).
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int QUEUE_DEPTH  = 16,
    parameter int VALEN        = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic [FETCH_WIDTH-1:0]        in_valid,
    input  logic [FETCH_WIDTH*VALEN-1:0]  in_vaddr,
    input  logic [FETCH_WIDTH*32-1:0]     in_instr,
    input  logic [FETCH_WIDTH*VALEN-1:0]  in_npc,
    input  logic                          in_excp_valid,
    input  logic [5:0]                    in_excp_ecode,
    output logic                          in_ready,
    output logic [DECODE_WIDTH-1:0]       out_valid,
    output logic [DECODE_WIDTH*VALEN-1:0] out_vaddr,
    output logic [DECODE_WIDTH*32-1:0]    out_instr,
    output logic [DECODE_WIDTH*VALEN-1:0] out_npc,
    output logic [DECODE_WIDTH-1:0]       out_excp_valid,
    output logic [DECODE_WIDTH*6-1:0]     out_excp_ecode,
    input  logic                          out_ready
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_full_cycles,
    output logic [31:0]                   perf_empty_cycles
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Highest occupancy that still leaves room for a full fetch group.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(QUEUE_DEPTH - FETCH_WIDTH);

    // Storage array
    logic [VALEN-1:0] vaddr_q      [QUEUE_DEPTH];
    logic [31:0]      instr_q      [QUEUE_DEPTH];
    logic [VALEN-1:0] npc_q        [QUEUE_DEPTH];
    logic [5:0]       ecode_q      [QUEUE_DEPTH];
    logic             excp_valid_q [QUEUE_DEPTH];

    // Pointers and occupancy
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Enqueue side
    logic [CNT_W-1:0] w_lane_off [FETCH_WIDTH];
    logic [PTR_W-1:0] w_wr_idx   [FETCH_WIDTH];
    logic [CNT_W-1:0] w_enq_cnt;
    logic             w_enq_fire;

    // Dequeue side
    logic [PTR_W-1:0]        w_rd_idx [DECODE_WIDTH];
    logic [DECODE_WIDTH-1:0] w_lane_avail;
    logic [CNT_W-1:0]        w_deq_cnt;
    logic                    w_excp_seen;

    // Ready depends only on registered occupancy, never on a same-cycle pop.
    assign in_ready   = (count_q <= READY_MAX);
    assign w_enq_fire = in_ready & (|in_valid) & ~flush_i;

    // Compact valid lanes: each valid lane's slot is the number of valid lanes below it.
    always_comb begin
        w_enq_cnt = '0;
        for (int j = 0; j < FETCH_WIDTH; j++) begin
            w_lane_off[j] = w_enq_cnt;
            w_wr_idx[j]   = tail_q + w_enq_cnt[PTR_W-1:0];
            w_enq_cnt     = w_enq_cnt + {{(CNT_W-1){1'b0}}, in_valid[j]};
        end
    end

    // Select presented lanes; an exception entry is only ever shown alone in lane 0.
    always_comb begin
        w_excp_seen = 1'b0;
        w_deq_cnt   = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            w_rd_idx[i]     = head_q + PTR_W'(i);
            w_excp_seen     = w_excp_seen | excp_valid_q[w_rd_idx[i]];
            w_lane_avail[i] = (count_q > CNT_W'(i)) & ~flush_i & ((i == 0) | ~w_excp_seen);
            w_deq_cnt       = w_deq_cnt + {{(CNT_W-1){1'b0}}, (w_lane_avail[i] & out_ready)};
        end
    end

    assign out_valid = w_lane_avail;

    generate
        for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_out_lane
            assign out_vaddr[g*VALEN +: VALEN] = vaddr_q[w_rd_idx[g]];
            assign out_instr[g*32 +: 32]       = instr_q[w_rd_idx[g]];
            assign out_npc[g*VALEN +: VALEN]   = npc_q[w_rd_idx[g]];
            assign out_excp_valid[g]           = excp_valid_q[w_rd_idx[g]];
            assign out_excp_ecode[g*6 +: 6]    = ecode_q[w_rd_idx[g]];
        end
    endgenerate

    // Next-state pointers/occupancy; flush discards any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_enq_fire) begin
                tail_d = tail_q + w_enq_cnt[PTR_W-1:0];
            end
            head_d  = head_q + w_deq_cnt[PTR_W-1:0];
            count_d = count_q + (w_enq_fire ? w_enq_cnt : '0) - w_deq_cnt;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload write of the compacted fetch group.
    always_ff @(posedge clk) begin
        if (!rst && w_enq_fire) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (in_valid[j]) begin
                    vaddr_q[w_wr_idx[j]] <= in_vaddr[j*VALEN +: VALEN];
                    instr_q[w_wr_idx[j]] <= in_instr[j*32 +: 32];
                    npc_q[w_wr_idx[j]]   <= in_npc[j*VALEN +: VALEN];
                    ecode_q[w_wr_idx[j]] <= in_excp_ecode;
                end
            end
        end
    end

    // Exception flag write: only the first valid lane of a group carries it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < QUEUE_DEPTH; k++) begin
                excp_valid_q[k] <= 1'b0;
            end
        end else if (w_enq_fire) begin
            for (int j = 0; j < FETCH_WIDTH; j++) begin
                if (in_valid[j]) begin
                    excp_valid_q[w_wr_idx[j]] <= in_excp_valid & (w_lane_off[j] == '0);
                end
            end
        end
    end

`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_full_q;
    logic [31:0] perf_empty_q;

    // Saturating stall/empty cycle counters; cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_full_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            if ((|in_valid) && !in_ready && (perf_full_q != 32'hFFFF_FFFF)) begin
                perf_full_q <= perf_full_q + 32'd1;
            end
            if ((count_q == '0) && (perf_empty_q != 32'hFFFF_FFFF)) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_full_cycles  = perf_full_q;
    assign perf_empty_cycles = perf_empty_q;
`endif

`ifndef SYNTHESIS
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
        !(w_enq_fire && !in_ready));
    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_W'(QUEUE_DEPTH));
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_queue
// Brief    : Self-checking bench for instr_fetch_queue. Directed scenarios
//            followed by randomized traffic, all compared against a queue-
//            based reference model of the fetch queue behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int FW    = 2;
    localparam int DW    = 2;
    localparam int DEPTH = 16;
    localparam int VALEN = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush_i;
    logic [FW-1:0]         in_valid;
    logic [FW*VALEN-1:0]   in_vaddr;
    logic [FW*32-1:0]      in_instr;
    logic [FW*VALEN-1:0]   in_npc;
    logic                  in_excp_valid;
    logic [5:0]            in_excp_ecode;
    logic                  in_ready;
    logic [DW-1:0]         out_valid;
    logic [DW*VALEN-1:0]   out_vaddr;
    logic [DW*32-1:0]      out_instr;
    logic [DW*VALEN-1:0]   out_npc;
    logic [DW-1:0]         out_excp_valid;
    logic [DW*6-1:0]       out_excp_ecode;
    logic                  out_ready;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0]           perf_full_cycles;
    logic [31:0]           perf_empty_cycles;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(
        .FETCH_WIDTH (FW),
        .DECODE_WIDTH(DW),
        .QUEUE_DEPTH (DEPTH),
        .VALEN       (VALEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .in_valid      (in_valid),
        .in_vaddr      (in_vaddr),
        .in_instr      (in_instr),
        .in_npc        (in_npc),
        .in_excp_valid (in_excp_valid),
        .in_excp_ecode (in_excp_ecode),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_vaddr     (out_vaddr),
        .out_instr     (out_instr),
        .out_npc       (out_npc),
        .out_excp_valid(out_excp_valid),
        .out_excp_ecode(out_excp_ecode),
        .out_ready     (out_ready)
`ifdef IFQ_PERF_CNT_EN
        ,
        .perf_full_cycles (perf_full_cycles),
        .perf_empty_cycles(perf_empty_cycles)
`endif
    );

    typedef struct packed {
        logic [VALEN-1:0] vaddr;
        logic [31:0]      instr;
        logic [VALEN-1:0] npc;
        logic             excp;
        logic [5:0]       ecode;
    } entry_t;

    entry_t      mq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_gen;
    logic [31:0] pa;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lane i is presented when it holds an entry, no flush is active, and no
    // exception entry sits at or ahead of it (an exception entry goes alone).
    function automatic logic [DW-1:0] exp_out_valid();
        logic [DW-1:0] v;
        bit            excp_ahead;
        v          = '0;
        excp_ahead = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (i < mq.size()) begin
                excp_ahead = excp_ahead | mq[i].excp;
                if (!flush_i && (i == 0 || !excp_ahead)) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    task automatic check_outputs();
        logic [DW-1:0] ev;
        ev = exp_out_valid();
        chk("in_ready", {63'd0, in_ready}, {63'd0, ((DEPTH - mq.size()) >= FW)});
        chk("out_valid", {62'd0, out_valid}, {62'd0, ev});
        for (int i = 0; i < DW; i++) begin
            if (ev[i]) begin
                chk($sformatf("vaddr[%0d]", i), {32'd0, out_vaddr[i*VALEN +: VALEN]}, {32'd0, mq[i].vaddr});
                chk($sformatf("instr[%0d]", i), {32'd0, out_instr[i*32 +: 32]}, {32'd0, mq[i].instr});
                chk($sformatf("npc[%0d]", i), {32'd0, out_npc[i*VALEN +: VALEN]}, {32'd0, mq[i].npc});
                chk($sformatf("excp[%0d]", i), {63'd0, out_excp_valid[i]}, {63'd0, mq[i].excp});
                if (mq[i].excp) begin
                    chk($sformatf("ecode[%0d]", i), {58'd0, out_excp_ecode[i*6 +: 6]}, {58'd0, mq[i].ecode});
                end
            end
        end
    endtask

    // Reference update at the clock edge using the inputs held this cycle.
    task automatic model_step();
        logic [DW-1:0] ov;
        int            ndeq;
        bit            rdy;
        bit            first;
        entry_t        e;
        if (rst || flush_i) begin
            mq.delete();
        end else begin
            ov   = exp_out_valid();
            rdy  = ((DEPTH - mq.size()) >= FW);
            ndeq = out_ready ? $countones(ov) : 0;
            for (int k = 0; k < ndeq; k++) void'(mq.pop_front());
            if (rdy && (|in_valid)) begin
                first = 1'b1;
                for (int j = 0; j < FW; j++) begin
                    if (in_valid[j]) begin
                        e.vaddr = in_vaddr[j*VALEN +: VALEN];
                        e.instr = in_instr[j*32 +: 32];
                        e.npc   = in_npc[j*VALEN +: VALEN];
                        e.excp  = first & in_excp_valid;
                        e.ecode = in_excp_ecode;
                        first   = 1'b0;
                        mq.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (!rst) check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_group(input logic [FW-1:0] v, input bit ex, input logic [5:0] ec);
        in_valid      = v;
        in_excp_valid = ex;
        in_excp_ecode = ec;
        for (int j = 0; j < FW; j++) begin
            in_vaddr[j*VALEN +: VALEN] = pc_gen;
            in_instr[j*32 +: 32]       = $urandom;
            in_npc[j*VALEN +: VALEN]   = pc_gen + 32'd4;
            pc_gen                     = pc_gen + 32'd4;
        end
    endtask

    task automatic idle();
        in_valid      = '0;
        in_excp_valid = 1'b0;
        in_excp_ecode = '0;
        flush_i       = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_vaddr  = '0;
        in_instr  = '0;
        in_npc    = '0;
        pc_gen    = 32'h1c00_0000;
        idle();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_out_valid", {62'd0, out_valid}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Single full group becomes visible one cycle later.
        set_group(2'b11, 1'b0, 6'd0);
        cycle();
        idle();
        chk("first_out_valid", {62'd0, out_valid}, 64'd3);
        chk("first_pc0", {32'd0, out_vaddr[31:0]}, 64'h1c00_0000);
        chk("first_pc1", {32'd0, out_vaddr[63:32]}, 64'h1c00_0004);
        chk("first_in_ready", {63'd0, in_ready}, 64'd1);

        // Fill to 16; a ninth group is refused.
        for (int n = 0; n < 7; n++) begin
            set_group(2'b11, 1'b0, 6'd0);
            cycle();
        end
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        set_group(2'b11, 1'b0, 6'd0);
        cycle();
        idle();
        chk("full_still_stalled", {63'd0, in_ready}, 64'd0);
        chk("full_head_unchanged", {32'd0, out_vaddr[31:0]}, 64'h1c00_0000);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("drain_in_ready", {63'd0, in_ready}, 64'd1);
        chk("drain_head_pc", {32'd0, out_vaddr[31:0]}, 64'h1c00_0008);
        flush_i = 1'b1;
        cycle();
        idle();
        chk("flush_empty", {62'd0, out_valid}, 64'd0);

        // Non-contiguous mask compaction.
        set_group(2'b10, 1'b0, 6'd0);
        pa = in_vaddr[63:32];
        cycle();
        set_group(2'b11, 1'b0, 6'd0);
        cycle();
        idle();
        chk("compact_pc0", {32'd0, out_vaddr[31:0]}, {32'd0, pa});
        out_ready = 1'b1;
        cycle();
        cycle();
        out_ready = 1'b0;

        // Exception isolation.
        set_group(2'b01, 1'b0, 6'd0);
        cycle();
        set_group(2'b11, 1'b1, 6'h08);
        cycle();
        idle();
        chk("excp_pre_valid", {62'd0, out_valid}, 64'd1);
        chk("excp_pre_flag", {63'd0, out_excp_valid[0]}, 64'd0);
        out_ready = 1'b1;
        cycle();
        chk("excp_alone_valid", {62'd0, out_valid}, 64'd1);
        chk("excp_alone_flag", {63'd0, out_excp_valid[0]}, 64'd1);
        chk("excp_alone_ecode", {58'd0, out_excp_ecode[5:0]}, 64'h08);
        cycle();
        chk("excp_after_valid", {62'd0, out_valid}, 64'd1);
        chk("excp_after_flag", {63'd0, out_excp_valid[0]}, 64'd0);
        cycle();
        out_ready = 1'b0;

        // Flush at count=10 with simultaneous enqueue and dequeue.
        for (int n = 0; n < 5; n++) begin
            set_group(2'b11, 1'b0, 6'd0);
            cycle();
        end
        set_group(2'b11, 1'b0, 6'd0);
        out_ready = 1'b1;
        flush_i   = 1'b1;
        #1;
        chk("flush_cycle_valid", {62'd0, out_valid}, 64'd0);
        cycle();
        idle();
        out_ready = 1'b0;
        chk("post_flush_valid", {62'd0, out_valid}, 64'd0);
        chk("post_flush_ready", {63'd0, in_ready}, 64'd1);

        // Offset pointers to odd alignment, then stream across the 15->0 wrap.
        set_group(2'b01, 1'b0, 6'd0);
        cycle();
        idle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        set_group(2'b11, 1'b0, 6'd0);
        cycle();
        out_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            set_group(2'b11, 1'b0, 6'd0);
            cycle();
        end
        idle();
        out_ready = 1'b0;
        chk("wrap_steady_valid", {62'd0, out_valid}, 64'd3);
        chk("wrap_steady_ready", {63'd0, in_ready}, 64'd1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rst     = ($urandom_range(0, 99) == 0);
            set_group(FW'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 6'($urandom));
            flush_i = ($urandom_range(0, 29) == 0);
            if (n < 300) out_ready = ($urandom_range(0, 3) == 0);
            else         out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
